// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word, icache frame layout and icache FSM states.
// Frame tag field is sized for the smallest legal cache (2 sets); the cache zero-extends narrower tags.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_TAG_MAXW = 29;

    typedef struct packed {
        logic                       valid;
        logic [ICACHE_TAG_MAXW-1:0] tag;
        word_t                      data;
    } icache_frame_t;

    typedef enum logic {
        ICACHE_IDLE = 1'b0,
        ICACHE_FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_resp.sv
// Direct-mapped instruction cache, one word per block: same-cycle hit, miss penalty = memory latency + 1.
// Stalls the datapath (ihit=0) while a fill waits on iwait; a started fill always completes unless reset.
module icache_resp
    import cpu_types_pkg::*;
#(
    parameter int NSETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int IDXW = $clog2(NSETS);
    localparam int TAGW = 30 - IDXW;

    icache_state_t state_q, state_d;
    logic [29:0]   miss_addr_q;
    word_t         hit_count_q, hit_count_d;
    word_t         miss_count_q, miss_count_d;
    icache_frame_t frames_q [NSETS];

    logic [IDXW-1:0] req_idx, miss_idx;
    logic [TAGW-1:0] req_tag, miss_tag;
    icache_frame_t   req_frame;
    logic            lookup_hit;
    logic            miss_start;
    logic            fill_done;

    // Byte offset within the fetched word has no effect on the lookup.
    logic unused_addr_bits;
    assign unused_addr_bits = ^imemaddr[1:0];

    assign req_idx    = imemaddr[IDXW+1:2];
    assign req_tag    = imemaddr[31:IDXW+2];
    assign miss_idx   = miss_addr_q[IDXW-1:0];
    assign miss_tag   = miss_addr_q[29:IDXW];
    assign req_frame  = frames_q[req_idx];
    assign lookup_hit = req_frame.valid && (req_frame.tag == ICACHE_TAG_MAXW'(req_tag));

    // Outputs are forced quiet while nRST is low so a fill in flight is invisible during reset.
    always_comb begin
        state_d      = state_q;
        ihit         = 1'b0;
        imemload     = '0;
        iREN         = 1'b0;
        iaddr        = '0;
        miss_start   = 1'b0;
        fill_done    = 1'b0;
        if (nRST) begin
            case (state_q)
                ICACHE_IDLE: begin
                    if (imemREN) begin
                        if (lookup_hit) begin
                            ihit     = 1'b1;
                            imemload = req_frame.data;
                        end else begin
                            miss_start = 1'b1;
                            state_d    = ICACHE_FILL;
                        end
                    end
                end
                ICACHE_FILL: begin
                    iREN  = 1'b1;
                    iaddr = {miss_addr_q, 2'b00};
                    if (!iwait) begin
                        fill_done = 1'b1;
                        state_d   = ICACHE_IDLE;
                    end
                end
                default: state_d = ICACHE_IDLE;
            endcase
        end
        hit_count_d  = hit_count_q + {31'd0, ihit};
        miss_count_d = miss_count_q + {31'd0, fill_done};
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q      <= ICACHE_IDLE;
            miss_addr_q  <= '0;
            hit_count_q  <= '0;
            miss_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
            if (miss_start) begin
                miss_addr_q <= imemaddr[31:2];
            end
        end
    end

    // Only valid bits are reset; tag/data are don't-care until their set is filled.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            for (int i = 0; i < NSETS; i++) begin
                frames_q[i].valid <= 1'b0;
            end
        end else if (fill_done) begin
            frames_q[miss_idx] <= '{valid: 1'b1,
                                    tag:   ICACHE_TAG_MAXW'(miss_tag),
                                    data:  iload};
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_icache_resp.sv
// Directed bench for icache_resp: cold miss, hit stream, conflict, redirect, imemREN drop, reset mid-fill.
module tb_icache_resp;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    int nvec = 0;
    int nerr = 0;

    icache_resp #(.NSETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic ren, input logic [31:0] addr, input logic wt, input logic [31:0] ld);
        imemREN  = ren;
        imemaddr = addr;
        iwait    = wt;
        iload    = ld;
        #1;
    endtask

    // Starts in an IDLE cycle with addr missing; returns at the start of the cycle after completion.
    task automatic do_fill(input string tg, input logic [31:0] addr, input int nwait,
                           input logic [31:0] data, output int nren);
        nren = 0;
        drive(1'b1, addr, 1'b1, 32'h0);
        chk({tg, "_miss"}, {31'd0, ihit}, 32'd0);
        nren += int'(iREN);
        tick();
        for (int k = 0; k < nwait; k++) begin
            drive(1'b1, addr, 1'b1, 32'h0);
            chk({tg, "_iaddr"}, iaddr, {addr[31:2], 2'b00});
            nren += int'(iREN);
            tick();
        end
        drive(1'b1, addr, 1'b0, data);
        nren += int'(iREN);
        tick();
    endtask

    task automatic expect_hit(input string tg, input logic [31:0] addr, input logic [31:0] data);
        drive(1'b1, addr, 1'b1, 32'h0);
        chk({tg, "_ihit"}, {31'd0, ihit}, 32'd1);
        chk({tg, "_data"}, imemload, data);
        chk({tg, "_iren"}, {31'd0, iREN}, 32'd0);
        tick();
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 32'hFFFF_FFFF);
        tick();
        tick();
        nRST = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int nr;
        nRST = 1'b0;
        drive(1'b1, 32'h40, 1'b0, 32'hFFFF_FFFF);
        chk("rst_ihit", {31'd0, ihit}, 32'd0);
        chk("rst_imemload", imemload, 32'd0);
        chk("rst_iren", {31'd0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        tick();
        tick();
        chk("rst_hitcnt", hit_count, 32'd0);
        chk("rst_misscnt", miss_count, 32'd0);
        nRST = 1'b1;

        // Cold miss with three busy cycles.
        do_fill("cold", 32'h40, 3, 32'h8C22_0004, nr);
        chk("cold_iren_cycles", nr, 32'd4);
        chk("cold_misscnt", miss_count, 32'd1);
        expect_hit("cold_hit", 32'h40, 32'h8C22_0004);
        chk("cold_hitcnt", hit_count, 32'd1);

        expect_hit("byteoff", 32'h43, 32'h8C22_0004);
        chk("byteoff_hitcnt", hit_count, 32'd2);

        drive(1'b0, 32'h40, 1'b1, 32'h0);
        chk("noreq_ihit", {31'd0, ihit}, 32'd0);
        chk("noreq_imemload", imemload, 32'd0);
        chk("noreq_iren", {31'd0, iREN}, 32'd0);
        tick();
        chk("noreq_hitcnt", hit_count, 32'd2);

        // Hit stream over pre-filled words.
        do_fill("pf0", 32'h0, 1, 32'hAAAA_0000, nr);
        do_fill("pf4", 32'h4, 1, 32'hAAAA_0004, nr);
        do_fill("pf8", 32'h8, 1, 32'hAAAA_0008, nr);
        chk("pf_misscnt", miss_count, 32'd4);
        expect_hit("hs0", 32'h0, 32'hAAAA_0000);
        expect_hit("hs4", 32'h4, 32'hAAAA_0004);
        expect_hit("hs8", 32'h8, 32'hAAAA_0008);
        chk("hs_hitcnt", hit_count, 32'd5);

        // Conflict: 0x10 and 0x50 share set 4.
        do_reset();
        do_fill("cf10", 32'h10, 2, 32'h1111_0010, nr);
        expect_hit("cf10_hit", 32'h10, 32'h1111_0010);
        do_fill("cf50", 32'h50, 2, 32'h5555_0050, nr);
        expect_hit("cf50_hit", 32'h50, 32'h5555_0050);
        do_fill("cf10_again", 32'h10, 1, 32'h2222_0010, nr);
        chk("cf_misscnt", miss_count, 32'd3);
        expect_hit("cf10_new", 32'h10, 32'h2222_0010);

        // Redirect mid-fill: 0x100 in flight, datapath jumps to 0x200.
        drive(1'b1, 32'h100, 1'b1, 32'h0);
        chk("rd_miss", {31'd0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h200, 1'b1, 32'h0);
        chk("rd_iaddr_hold", iaddr, 32'h100);
        chk("rd_ihit_fill", {31'd0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h200, 1'b0, 32'hDEAD_0100);
        chk("rd_iaddr_done", iaddr, 32'h100);
        chk("rd_iren_done", {31'd0, iREN}, 32'd1);
        tick();
        chk("rd_misscnt", miss_count, 32'd4);
        drive(1'b1, 32'h200, 1'b1, 32'h0);
        chk("rd_200_miss", {31'd0, ihit}, 32'd0);
        tick();
        drive(1'b1, 32'h200, 1'b0, 32'hBEEF_0200);
        chk("rd_200_iren", {31'd0, iREN}, 32'd1);
        chk("rd_200_iaddr", iaddr, 32'h200);
        tick();
        expect_hit("rd_200_hit", 32'h200, 32'hBEEF_0200);

        // imemREN drops mid-fill: fill still lands at 0x100.
        drive(1'b1, 32'h100, 1'b1, 32'h0);
        tick();
        drive(1'b0, 32'h300, 1'b1, 32'h0);
        chk("drop_iaddr", iaddr, 32'h100);
        tick();
        drive(1'b0, 32'h300, 1'b0, 32'hC0DE_0100);
        tick();
        expect_hit("drop_100_hit", 32'h100, 32'hC0DE_0100);

        // Reset while the fill completes: nothing written, counters cleared.
        drive(1'b1, 32'h180, 1'b1, 32'h0);
        tick();
        drive(1'b1, 32'h180, 1'b1, 32'h0);
        chk("rmf_iren", {31'd0, iREN}, 32'd1);
        tick();
        nRST = 1'b0;
        drive(1'b1, 32'h180, 1'b0, 32'hBAD0_0180);
        chk("rmf_iren_rst", {31'd0, iREN}, 32'd0);
        chk("rmf_iaddr_rst", iaddr, 32'd0);
        tick();
        nRST = 1'b1;
        drive(1'b1, 32'h180, 1'b1, 32'h0);
        chk("rmf_miss", {31'd0, ihit}, 32'd0);
        chk("rmf_hitcnt", hit_count, 32'd0);
        chk("rmf_misscnt", miss_count, 32'd0);
        tick();
        drive(1'b1, 32'h180, 1'b1, 32'h0);
        chk("rmf_refill_iren", {31'd0, iREN}, 32'd1);
        chk("rmf_refill_iaddr", iaddr, 32'h180);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/icache_resp.md
ICACHE_RESP -- requirements
Module: icache_resp

Interface
REQ-001 Parameter NSETS, 16, number of direct-mapped sets; one 32-bit word per block; power of two, 2..64.
REQ-002 Port CLK  input  1  single clock; all state updates on rising edge.
REQ-003 Port nRST  input  1  synchronous active-low reset, sampled on rising CLK.
REQ-004 Port imemREN  input  1  datapath instruction read request.
REQ-005 Port imemaddr  input  32  datapath fetch byte address; bits [1:0] ignored.
REQ-006 Port ihit  output  1  imemload valid for current imemaddr this cycle.
REQ-007 Port imemload  output  32  instruction word returned to datapath.
REQ-008 Port iREN  output  1  read request to memory controller.
REQ-009 Port iaddr  output  32  word-aligned memory read address.
REQ-010 Port iwait  input  1  memory busy; iload valid in the cycle iwait=0 while iREN=1.
REQ-011 Port iload  input  32  memory read data.
REQ-012 Port hit_count  output  32  count of hit cycles since reset.
REQ-013 Port miss_count  output  32  count of completed fills since reset.

Function
REQ-014 Address split: index = imemaddr[log2(NSETS)+1:2]; tag = imemaddr[31:log2(NSETS)+2].
REQ-015 Storage per set: valid bit, tag, 32-bit data; register array, no SRAM macro.
REQ-016 FSM states: IDLE, FILL.
REQ-017 In IDLE, ihit = imemREN & valid[index] & tag match, combinational same cycle; imemload = data[index] while ihit=1, else 0.
REQ-018 IDLE to FILL when imemREN=1 and ihit=0; full word address latched as miss_addr in that cycle.
REQ-019 In FILL, iREN=1, iaddr={miss_addr[31:2],2'b00}, ihit=0; iaddr held stable regardless of imemaddr changes.
REQ-020 In FILL, iwait=1 holds state; iwait=0 writes iload, tag, valid=1 into set of miss_addr and returns to IDLE.
REQ-021 Outside FILL, iREN=0 and iaddr=0.
REQ-022 Miss latency: hit on the cycle after fill completion if imemaddr still equals miss_addr; minimum miss penalty = memory latency + 1 cycle.
REQ-023 imemaddr changing during FILL (redirect or flush): fill completes to miss_addr unchanged; new address evaluated in IDLE the next cycle.
REQ-024 imemREN dropping during FILL: fill still completes; no abort.
REQ-025 Conflict miss: fill overwrites resident line unconditionally; no write-back, icache never dirty.
REQ-026 hit_count increments by 1 each cycle ihit=1; miss_count increments by 1 on each fill completion; both wrap from 2^32-1 to 0.
REQ-027 imemREN=0 in IDLE: ihit=0, no state change, no count change.

Reset
REQ-028 nRST=0 at a rising edge: state=IDLE, all valid bits=0, hit_count=0, miss_count=0, miss_addr=0; tag/data contents need not be cleared.
REQ-029 Reset during FILL abandons the fill with no array write; any iload in that cycle discarded.
REQ-030 Outputs during and after reset: ihit=0, imemload=0, iREN=0, iaddr=0 until a new request.

Structure
REQ-031 Shared package cpu_types_pkg supplies word_t and a new icache_frame_t struct (valid, tag, data); tag width derived from NSETS inside the module.
REQ-032 Single flat module, no sub-modules; FSM, array and counters in one block.

Verification
REQ-033 Cold miss: after reset, imemREN=1, imemaddr=0x00000040, memory returns 0x8C220004 after 3 iwait cycles -> iREN=1 for 4 cycles, iaddr=0x40, ihit=1 with imemload=0x8C220004 on the next cycle, miss_count=1.
REQ-034 Hit stream: addresses 0x0,0x4,0x8 pre-filled, requested back-to-back -> ihit=1 each cycle, iREN=0 throughout, hit_count +3.
REQ-035 Conflict: fill 0x00000010 then 0x00000050 (same index, NSETS=16) -> second fill replaces line; later request to 0x10 misses again, miss_count=3.
REQ-036 Redirect mid-fill: miss on 0x100, imemaddr changed to 0x200 during FILL -> iaddr stays 0x100, line 0x100 valid, next cycle a FILL for 0x200 starts.
REQ-037 Reset mid-fill: nRST=0 during FILL with iwait=0 -> no line written, request to same address misses, counters 0.
REQ-038 Byte offset: imemaddr=0x00000043 after fill of 0x40 -> ihit=1, same data as 0x40.
